// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: default widths, opcode map, field
// positions and the fetch controller state encoding.
package cpu_pkg;

  // Default widths for the program counter and the instruction word.
  localparam int ADDR_W_DEF = 4;
  localparam int INS_W_DEF  = 11;

  // Instruction layout: [10:8] opcode, [7:4] jump target / operand A,
  // [3:0] immediate / operand B.
  localparam int OPC_W   = 3;
  localparam int TGT_LSB = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 4;

  // Control-flow opcodes resolved in the fetch stage.
  localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
  localparam logic [OPC_W-1:0] OP_BRZ = 3'b011;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b100;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // True when an opcode is a control-flow instruction handled at fetch.
  function automatic logic is_flow_op(input logic [OPC_W-1:0] op);
    return (op == OP_JMP) || (op == OP_BRZ);
  endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Control, program-load and instruction-issue signals between the fetch
// stage and whoever drives it (loader/testbench on the master side).
interface ins_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INS_W  = INS_W_DEF
) ();

  logic              start;
  logic              stall;
  logic              zero_flag;
  logic              PROG_WE;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [INS_W-1:0]  PROG_DATA;
  logic [INS_W-1:0]  INS;
  logic              ins_valid;
  logic [ADDR_W-1:0] PC;
  logic              halted;

  // Loader / controller side.
  modport master (
    output start, stall, zero_flag, PROG_WE, PROG_ADDR, PROG_DATA,
    input  INS, ins_valid, PC, halted
  );

  // Fetch stage side.
  modport slave (
    input  start, stall, zero_flag, PROG_WE, PROG_ADDR, PROG_DATA,
    output INS, ins_valid, PC, halted
  );

endinterface

// File: rtl/ins_mem.sv
// Program store: 2^ADDR_W x DATA_W array, synchronous write, asynchronous
// read so the fetch stage sees MEM[PC] in the same cycle. Contents are not
// reset, so a program survives rst_n.
module ins_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Synchronous write; a write at edge N is readable right after edge N.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: program counter, program store, registered
// instruction output and the IDLE/RUN/HALT controller.
// Build option: define INS_FETCH_BRANCH_EN to make OP_BRZ a conditional
// branch on zero_flag; otherwise OP_BRZ fetches like any sequential
// instruction and zero_flag is ignored.
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INS_W  = INS_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  ins_fetch_if.slave bus
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INS_W-1:0]  r_ins;
  logic              r_ins_valid;
  logic              r_halted;

  logic [INS_W-1:0]  w_fetch;
  logic [OPC_W-1:0]  w_op;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_take;
  logic              w_self_jump;
  logic              w_prog_we;

  // Program writes are only accepted while not executing.
  assign w_prog_we = bus.PROG_WE && (r_state != ST_RUN);

  ins_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (INS_W)
  ) u_ins_mem (
    .clk     (clk),
    .i_we    (w_prog_we),
    .i_waddr (bus.PROG_ADDR),
    .i_wdata (bus.PROG_DATA),
    .i_raddr (r_pc),
    .o_rdata (w_fetch)
  );

  // Decode just enough of the fetched word to resolve control flow.
  assign w_op  = w_fetch[INS_W-1 -: OPC_W];
  assign w_tgt = w_fetch[TGT_LSB +: ADDR_W];

`ifdef INS_FETCH_BRANCH_EN
  assign w_take = (w_op == OP_JMP) || ((w_op == OP_BRZ) && bus.zero_flag);
`else
  // zero_flag has no consumer in this build.
  logic w_unused_zero_flag;
  assign w_unused_zero_flag = bus.zero_flag;
  assign w_take = (w_op == OP_JMP);
`endif

  // PC wraps silently from the top address back to 0.
  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign w_pc_next   = w_take ? w_tgt : w_pc_inc;
  // A taken jump onto itself can never make progress: treat it as halt.
  assign w_self_jump = w_take && (w_tgt == r_pc) && is_flow_op(w_op);

  // Controller, PC and instruction register in one registered FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_ins       <= '0;
      r_ins_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc        <= '0;
          r_ins_valid <= 1'b0;
          r_halted    <= 1'b0;
          if (bus.start) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stall) begin
            // Stall wins over everything, including halt detection.
            r_ins_valid <= 1'b0;
          end else begin
            r_ins       <= w_fetch;
            r_ins_valid <= 1'b1;
            r_pc        <= w_pc_next;
            if (w_self_jump) begin
              // The self-jump issues normally; halted follows one edge later.
              r_state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_ins_valid <= 1'b0;
          if (bus.start) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_halted <= 1'b0;
          end else begin
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_pc        <= '0;
          r_ins_valid <= 1'b0;
          r_halted    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.INS       = r_ins;
  assign bus.ins_valid = r_ins_valid;
  assign bus.PC        = r_pc;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed program scenarios followed by
// randomized programs and control, all compared against a cycle-level
// behavioural model of the fetch rules.
module tb_ins_fetch;

`ifdef INS_FETCH_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ins_fetch_if #(.ADDR_W(4), .INS_W(11)) bus ();

  ins_fetch #(.ADDR_W(4), .INS_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 0 = idle, 1 = running, 2 = halted.
  logic [10:0] m_mem [16];
  int          m_mode;
  int          m_pc;
  logic [10:0] m_ins;
  bit          m_valid;
  bit          m_halted;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_pc     = 0;
    m_ins    = '0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
  endtask

  // One clock edge of the fetch rules, applied to the inputs seen at the edge.
  task automatic model_step(input bit s, input bit st, input bit zf, input bit we,
                            input int a, input logic [10:0] d);
    logic [10:0] f;
    int          op;
    int          tgt;
    bit          jump;
    case (m_mode)
      0: begin
        if (we) m_mem[a] = d;
        m_valid = 1'b0;
        m_pc    = 0;
        if (s) m_mode = 1;
      end
      1: begin
        if (st) begin
          m_valid = 1'b0;
        end else begin
          f     = m_mem[m_pc];
          op    = int'(f[10:8]);
          tgt   = int'(f[7:4]);
          jump  = (op == 4) || (BR_EN && op == 3 && zf);
          m_ins   = f;
          m_valid = 1'b1;
          if (jump && tgt == m_pc) m_mode = 2;
          m_pc = jump ? tgt : (m_pc + 1) % 16;
        end
      end
      default: begin
        if (we) m_mem[a] = d;
        m_valid = 1'b0;
        if (s) begin
          m_mode   = 0;
          m_pc     = 0;
          m_halted = 1'b0;
        end else begin
          m_halted = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check_value("PC", 32'(bus.PC), 32'(m_pc));
    check_value("INS", 32'(bus.INS), 32'(m_ins));
    check_value("ins_valid", 32'(bus.ins_valid), 32'(m_valid));
    check_value("halted", 32'(bus.halted), 32'(m_halted));
  endtask

  task automatic cycle(input bit s, input bit st, input bit zf, input bit we,
                       input int a, input logic [10:0] d);
    logic [3:0] a4;
    a4 = a[3:0];
    bus.start     = s;
    bus.stall     = st;
    bus.zero_flag = zf;
    bus.PROG_WE   = we;
    bus.PROG_ADDR = a4;
    bus.PROG_DATA = d;
    @(posedge clk);
    model_step(s, st, zf, we, a, d);
    #1;
    check_outputs();
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 11'h000);
  endtask

  task automatic load(input int a, input logic [10:0] d);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic go();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 11'h000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("rst_PC", 32'(bus.PC), 32'h0);
    check_value("rst_INS", 32'(bus.INS), 32'h0);
    check_value("rst_valid", 32'(bus.ins_valid), 32'h0);
    check_value("rst_halted", 32'(bus.halted), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] prog [16];
    int          r;
    logic [2:0]  op;
    logic [7:0]  lo;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.zero_flag = 1'b0;
    bus.PROG_WE   = 1'b0;
    bus.PROG_ADDR = '0;
    bus.PROG_DATA = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_value("reset_PC", 32'(bus.PC), 32'h0);
    check_value("reset_INS", 32'(bus.INS), 32'h0);
    check_value("reset_valid", 32'(bus.ins_valid), 32'h0);
    check_value("reset_halted", 32'(bus.halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential issue of MEM[0..2].
    for (int i = 0; i < 16; i++) load(i, 11'h000);
    load(0, 11'h001);
    load(1, 11'h002);
    load(2, 11'h003);
    go();
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_value("seq_INS", 32'(bus.INS), 32'(k));
      check_value("seq_PC", 32'(bus.PC), 32'(k));
      check_value("seq_valid", 32'(bus.ins_valid), 32'h1);
    end
    $display("txn seq: issued 001 002 003");
    do_reset();

    // Unconditional jump with no bubble.
    load(1, 11'h450);
    load(5, 11'h055);
    go();
    tick();
    tick();
    check_value("jmp_PC", 32'(bus.PC), 32'h5);
    tick();
    check_value("jmp_INS", 32'(bus.INS), 32'h055);
    check_value("jmp_PC_after", 32'(bus.PC), 32'h6);
    $display("txn jmp: 001 450 055 PC=%0d", bus.PC);
    do_reset();

    // Zero-flag branch, taken then not taken.
    load(1, 11'h002);
    load(2, 11'h300);
    load(3, 11'h430);
    go();
    tick();
    tick();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 11'h000);
    check_value("brz_taken_PC", 32'(bus.PC), BR_EN ? 32'h0 : 32'h3);
    $display("txn brz zf=1: PC=%0d", bus.PC);
    do_reset();
    go();
    tick();
    tick();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 11'h000);
    check_value("brz_not_PC", 32'(bus.PC), 32'h3);
    $display("txn brz zf=0: PC=%0d", bus.PC);

    // Self-jump halt and return to idle.
    tick();
    check_value("halt_issue_INS", 32'(bus.INS), 32'h430);
    check_value("halt_issue_valid", 32'(bus.ins_valid), 32'h1);
    tick();
    check_value("halt_flag", 32'(bus.halted), 32'h1);
    check_value("halt_INS_hold", 32'(bus.INS), 32'h430);
    tick();
    go();
    check_value("halt_exit_PC", 32'(bus.PC), 32'h0);
    check_value("halt_exit_flag", 32'(bus.halted), 32'h0);
    tick();
    $display("txn halt: JMP 3 halted then idle");

    // Stall freeze, write ignored during run, stalled self-jump.
    go();
    tick();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 11'h000);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2, 11'h7ff);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 11'h000);
    check_value("stall_PC", 32'(bus.PC), 32'h1);
    check_value("stall_INS", 32'(bus.INS), 32'h001);
    check_value("stall_valid", 32'(bus.ins_valid), 32'h0);
    tick();
    check_value("stall_resume_INS", 32'(bus.INS), 32'h002);
    tick();
    check_value("run_we_ignored", 32'(bus.INS), 32'h300);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 11'h000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 11'h000);
    check_value("stall_selfjmp_halted", 32'(bus.halted), 32'h0);
    tick();
    tick();
    check_value("stall_then_halt", 32'(bus.halted), 32'h1);
    go();
    $display("txn stall: frozen 3 cycles, resumed, halted after release");

    // Async reset mid-run at PC=7, program preserved, wrap 15 -> 0.
    for (int i = 0; i < 16; i++) load(i, 11'(i + 1));
    go();
    repeat (7) tick();
    check_value("pre_rst_PC", 32'(bus.PC), 32'h7);
    do_reset();
    go();
    tick();
    check_value("restart_INS", 32'(bus.INS), 32'h001);
    repeat (14) tick();
    check_value("pc15", 32'(bus.PC), 32'hf);
    tick();
    check_value("wrap_INS", 32'(bus.INS), 32'h010);
    check_value("wrap_PC", 32'(bus.PC), 32'h0);
    tick();
    $display("txn reset/wrap: restart 001, wrap to PC=%0d", bus.PC);
    do_reset();

    // Randomized programs and control.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) begin
        r  = int'($urandom % 10);
        lo = 8'($urandom);
        if (r < 3)      op = 3'b100;
        else if (r < 5) op = 3'b011;
        else            op = 3'($urandom);
        prog[i] = {op, lo};
        load(i, prog[i]);
      end
      go();
      for (int c = 0; c < 40; c++) begin
        cycle(($urandom % 8) == 0, ($urandom % 4) == 0, 1'($urandom),
              ($urandom % 6) == 0, int'($urandom % 16), 11'($urandom));
      end
      $display("txn random %0d: PC=%0d halted=%0d errors=%0d", it, bus.PC, bus.halted, n_errors);
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
